// File: rtl/ps2_scancode_ctrl.sv
// PS/2 set-2 scan-code sequencer: drains the receiver FIFO, folds E0/F0 prefixes into key events.
// Optional build macro TYPEMATIC_FILTER_EN suppresses auto-repeat makes of keys already held.
module ps2_scancode_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             key_valid,
  input  logic             key_ack,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nd_n_q, nd_n_d;
  logic             valid_q, valid_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ext_f_q, ext_f_d;
  logic             brk_f_q, brk_f_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             latch_s;
  logic             to_run_s;
  logic             emit_s;

`ifdef TYPEMATIC_FILTER_EN
  logic [511:0]     held_q, held_d;
  logic [8:0]       held_idx_s;
  assign held_idx_s = {ext_f_q, byte_q};
`endif

  // Next-state and registered-output logic for the pop/decode sequencer.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    nd_n_d   = 1'b1;
    valid_d  = valid_q;
    code_d   = code_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | kbd_overflow;
    ext_f_d  = ext_f_q;
    brk_f_d  = brk_f_q;
    to_d     = to_q;
    latch_s  = 1'b0;
    emit_s   = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    held_d   = held_q;
`endif

    if (valid_q && key_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      S_IDLE: begin
        // A pending event back-pressures the FIFO: nothing is popped until it is accepted.
        if (kbd_ready && !valid_q) begin
          byte_d  = kbd_data;
          nd_n_d  = 1'b0;
          latch_s = 1'b1;
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_IDLE;
        case (byte_q)
          8'hE0: ext_f_d = 1'b1;
          8'hF0: brk_f_d = 1'b1;
          8'hE1: ext_f_d = ext_f_q;
          default: begin
`ifdef TYPEMATIC_FILTER_EN
            if (brk_f_q) begin
              held_d[held_idx_s] = 1'b0;
              emit_s             = 1'b1;
            end else if (!held_q[held_idx_s]) begin
              held_d[held_idx_s] = 1'b1;
              emit_s             = 1'b1;
            end else begin
              emit_s             = 1'b0;
            end
`else
            emit_s = 1'b1;
`endif
            if (emit_s) begin
              code_d  = byte_q;
              ext_d   = ext_f_q;
              rel_d   = brk_f_q;
              valid_d = 1'b1;
              if (!brk_f_q) begin
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                cnt_d = cnt_q;
              end
            end else begin
              valid_d = valid_q;
            end
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Orphaned prefixes expire if no follow-up byte shows up in time.
    to_run_s = (ext_f_q | brk_f_q) && (state_q == S_IDLE) && !kbd_ready;
    if (latch_s) begin
      to_d = '0;
    end else if (to_run_s) begin
      if (to_q == TO_LAST) begin
        to_d    = '0;
        ext_f_d = 1'b0;
        brk_f_d = 1'b0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = to_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q  <= 8'h00;
      nd_n_q  <= 1'b1;
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ext_f_q <= 1'b0;
      brk_f_q <= 1'b0;
      to_q    <= '0;
`ifdef TYPEMATIC_FILTER_EN
      held_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      nd_n_q  <= nd_n_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ext_f_q <= ext_f_d;
      brk_f_q <= brk_f_d;
      to_q    <= to_d;
`ifdef TYPEMATIC_FILTER_EN
      held_q  <= held_d;
`endif
    end
  end

  assign kbd_nextdata_n = nd_n_q;
  assign key_valid      = valid_q;
  assign key_code       = code_q;
  assign key_ext        = ext_q;
  assign key_release    = rel_q;
  assign press_cnt      = cnt_q;
  assign ovf_seen       = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Randomized/directed bench for ps2_scancode_ctrl with a byte-stream reference model and FIFO model.
module tb_ps2_scancode_ctrl;

  localparam int CNT_W = 8;
  localparam int TO    = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             kbd_ready;
  logic [7:0]       kbd_data;
  logic             kbd_overflow;
  logic             kbd_nextdata_n;
  logic             key_valid;
  logic             key_ack;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic [CNT_W-1:0] press_cnt;
  logic             ovf_seen;

  always #5 clk = ~clk;

  ps2_scancode_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
    .key_valid(key_valid), .key_ack(key_ack), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .press_cnt(press_cnt),
    .ovf_seen(ovf_seen)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_q[$];
  logic [9:0]  exp_q[$];
  bit          m_ext, m_brk;
  int          m_cnt;
  bit          m_held[512];
  int          ack_mode;
  bit          valid_prev;
  logic [9:0]  cur_ev, last_ev;
  int          pop_cnt, ev_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_cnt = 0;
    foreach (m_held[i]) m_held[i] = 1'b0;
    exp_q.delete();
  endfunction

  // Reference decoding of one scan byte in stream order.
  function automatic void m_byte(input logic [7:0] b);
    bit emit;
    int idx;
    emit = 1'b1;
    idx  = (m_ext ? 256 : 0) + int'(b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE1) emit = 1'b0;
    else begin
`ifdef TYPEMATIC_FILTER_EN
      if (m_brk) m_held[idx] = 1'b0;
      else if (m_held[idx]) emit = 1'b0;
      else m_held[idx] = 1'b1;
`endif
      if (emit) begin
        exp_q.push_back({b, m_ext, m_brk});
        if (!m_brk) m_cnt++;
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endfunction

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    m_byte(b);
    kbd_ready = 1'b1;
    kbd_data  = rx_q[0];
  endtask

  // One clock: receiver FIFO model, handshake/event checks, ack policy.
  task automatic tick();
    bit nd, hs;
    nd = kbd_nextdata_n;
    hs = key_valid && key_ack;
    if (hs) chk("stable_at_ack", {key_code, key_ext, key_release}, cur_ev);
    @(posedge clk); #1;
    if (!nd && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      pop_cnt++;
    end
    kbd_ready = (rx_q.size() > 0);
    kbd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    if (hs) chk("ack_fall", key_valid, 0);
    if (key_valid && !valid_prev) begin
      cur_ev  = {key_code, key_ext, key_release};
      last_ev = cur_ev;
      ev_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_event: observed %0h expected none", cur_ev);
        end
      end else begin
        chk("event", cur_ev, exp_q.pop_front());
      end
    end
    valid_prev = key_valid;
    case (ack_mode)
      0:       key_ack = 1'b0;
      1:       key_ack = ($urandom_range(0, 2) == 0);
      default: key_ack = 1'b1;
    endcase
  endtask

  task automatic drain(input int maxc);
    int n, idle;
    n = 0; idle = 0;
    ack_mode = 1;
    while (n < maxc && idle < 6) begin
      tick();
      n++;
      if (rx_q.size() == 0 && !key_valid && kbd_nextdata_n) idle++;
      else idle = 0;
    end
    chk("drain_in_time", (n < maxc), 1);
    chk("all_events_seen", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    m_reset();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 9))
      0:       return 8'hE0;
      1:       return 8'hF0;
      2:       return 8'hE1;
      3:       return 8'h1C;
      4:       return 8'h32;
      5:       return 8'h75;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    int p0, e0, n;
    logic [7:0] b;
    rst = 1'b1; kbd_ready = 1'b0; kbd_data = 8'h00; kbd_overflow = 1'b0; key_ack = 1'b0;
    ack_mode = 0; valid_prev = 1'b0; cur_ev = '0; last_ev = '0; pop_cnt = 0; ev_cnt = 0;
    m_reset();
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", {kbd_nextdata_n, key_valid, key_code, key_ext, key_release, press_cnt, ovf_seen},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});

    // Single make, latency and ack.
    push(8'h1C);
    tick(); tick();
    chk("latency_not_yet", key_valid, 0);
    tick();
    chk("latency_valid", key_valid, 1);
    chk("t1_event", {key_code, key_ext, key_release}, {8'h1C, 2'b00});
    chk("t1_cnt", press_cnt, 1);
    ack_mode = 2; tick();
    ack_mode = 0; tick();
    chk("t1_cleared", key_valid, 0);

    // Extended break with both prefixes.
    push(8'hE0); push(8'hF0); push(8'h75);
    repeat (12) tick();
    chk("t2_valid", key_valid, 1);
    chk("t2_event", last_ev, {8'h75, 2'b11});
    chk("t2_cnt", press_cnt, 1);
    drain(200);

    // Back-pressure while an event is unaccepted.
    do_reset();
    ack_mode = 0; p0 = pop_cnt;
    push(8'h1C); push(8'h32);
    repeat (55) tick();
    chk("t3_pops", pop_cnt - p0, 1);
    chk("t3_fifo_left", rx_q.size(), 1);
    chk("t3_hold", {key_valid, key_code, kbd_nextdata_n}, {1'b1, 8'h1C, 1'b1});
    drain(200);
    chk("t3_second", last_ev, {8'h32, 2'b00});

    // Prefix timeout, then a short gap that keeps the prefix.
    do_reset();
    push(8'hF0);
    drain(100);
    repeat (TO + 10) tick();
    m_ext = 1'b0; m_brk = 1'b0;
    push(8'h1C);
    drain(100);
    chk("t4_after_timeout", last_ev, {8'h1C, 2'b00});
    push(8'hF0);
    drain(100);
    repeat (TO / 2) tick();
    push(8'h1C);
    drain(100);
    chk("t4_within_timeout", last_ev, {8'h1C, 2'b01});

    // Auto-repeat stream.
    do_reset();
    e0 = ev_cnt;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain(300);
`ifdef TYPEMATIC_FILTER_EN
    chk("t5_cnt", press_cnt, 1);
    chk("t5_events", ev_cnt - e0, 2);
`else
    chk("t5_cnt", press_cnt, 3);
    chk("t5_events", ev_cnt - e0, 4);
`endif

    // Sticky overflow and reset during a pop.
    kbd_overflow = 1'b1; tick(); kbd_overflow = 1'b0; tick();
    chk("ovf_set", ovf_seen, 1);
    push(8'h2B);
    repeat (10) tick();
    chk("ovf_sticky", ovf_seen, 1);
    drain(100);
    ack_mode = 0;
    push(8'h4D);
    n = 0;
    while (kbd_nextdata_n && n < 10) begin tick(); n++; end
    chk("t6_in_pop", kbd_nextdata_n, 0);
    rst = 1'b1; tick();
    chk("t6_rst_pop", {kbd_nextdata_n, key_valid, ovf_seen, press_cnt}, {1'b1, 1'b0, 1'b0, 8'h00});
    rst = 1'b0; rx_q.delete(); kbd_ready = 1'b0; m_reset();
    push(8'h1C);
    repeat (6) tick();
    push(8'h32);
    ack_mode = 2; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rx_q.delete(); kbd_ready = 1'b0; m_reset(); ack_mode = 0;
    chk("t6_rst_priority", {key_valid, press_cnt}, {1'b0, 8'h00});
    repeat (8) tick();

    // Randomized bursts against the reference model.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ack_mode = 1;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        push(pick());
        repeat ($urandom_range(0, 4)) tick();
      end
      b = 8'($urandom_range(1, 3) * 8'h11);
      push(b);
      if (k % 3 == 2) drain(2000);
      else repeat ($urandom_range(0, 6)) tick();
    end
    drain(4000);
    chk("rand_cnt", press_cnt, 8'(m_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
